vending_fsm_param: RTL

Parametrised successor to the coin-operated vending controller. It accumulates credit from three coin denominations and vends when credit reaches a programmable price. Change and refunds are paid out as unit pulses. An inactivity timer that restarts on every coin triggers a full refund, and a cancel input does the same. It sits between the coin acceptor front end (coin codes) and the dispense/payout actuators (pr/vend_ack, change).

---
 rtl/vending_fsm_param.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/vending_fsm_param.sv
// Coin-operated vending controller with programmable price, credit ceiling and inactivity refund.
// Change and refunds leave the machine as one credit unit per cycle on the change output.
module vending_fsm_param #(
    parameter int PRICE      = 3,
    parameter int CREDIT_W   = 4,
    parameter int MAX_CREDIT = 15,
    parameter int COIN1_VAL  = 1,
    parameter int COIN2_VAL  = 2,
    parameter int COIN3_VAL  = 5,
    parameter int TIMEOUT    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                pr,
    output logic                change,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CREDIT_W:0]   L_MAX     = MAX_CREDIT[CREDIT_W:0];
    localparam logic [CREDIT_W:0]   L_PRICE   = PRICE[CREDIT_W:0];
    localparam logic [CREDIT_W-1:0] L_PRICE_C = PRICE[CREDIT_W-1:0];
    localparam logic [CREDIT_W-1:0] L_ONE_C   = CREDIT_W'(1'b1);
    localparam logic [TMR_W-1:0]    L_TMR_ONE = TMR_W'(1'b1);
    localparam logic [TMR_W-1:0]    L_TIMEOUT = TIMEOUT[TMR_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] w_credit_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic [TMR_W-1:0]    w_timer_inc;
    logic                r_pr;
    logic                r_change;
    logic                r_coin_rej;
    logic                w_rej_nxt;
    logic                w_coin_in;
    logic                w_coin_ok;
    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_sum;

    // Sum is one bit wider than credit so an over-ceiling coin is caught, not wrapped.
    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W:0] v;
        case (code)
            2'd1:    v = COIN1_VAL[CREDIT_W:0];
            2'd2:    v = COIN2_VAL[CREDIT_W:0];
            2'd3:    v = COIN3_VAL[CREDIT_W:0];
            default: v = {(CREDIT_W+1){1'b0}};
        endcase
        return v;
    endfunction

    // Next-state, credit, inactivity timer and reject decision.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_timer_nxt  = r_timer;
        w_rej_nxt    = 1'b0;
        w_coin_val   = coin_value(coin);
        w_sum        = {1'b0, r_credit} + w_coin_val;
        w_coin_in    = (coin != 2'd0);
        w_coin_ok    = w_coin_in && (w_sum <= L_MAX);
        w_timer_inc  = r_timer + L_TMR_ONE;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                w_rej_nxt = w_coin_in && !w_coin_ok;
                if (w_coin_ok) begin
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                    w_timer_nxt  = {TMR_W{1'b0}};
                end else begin
                    w_credit_nxt = r_credit;
                end
                // Cancel refunds the credit including a coin accepted on the same edge.
                if ((r_state == S_CREDIT) && cancel) begin
                    w_state_nxt = S_CHANGE;
                    w_timer_nxt = {TMR_W{1'b0}};
                end else if (w_coin_ok) begin
                    if (w_sum >= L_PRICE) begin
                        w_state_nxt = S_VEND;
                    end else begin
                        w_state_nxt = S_CREDIT;
                    end
                end else if ((r_state == S_CREDIT) && !w_coin_in) begin
                    if (w_timer_inc == L_TIMEOUT) begin
                        w_state_nxt = S_CHANGE;
                        w_timer_nxt = {TMR_W{1'b0}};
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_VEND: begin
                w_rej_nxt = w_coin_in;
                if (vend_ack) begin
                    w_credit_nxt = r_credit - L_PRICE_C;
                    if (r_credit == L_PRICE_C) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_CHANGE;
                    end
                end else begin
                    w_state_nxt = S_VEND;
                end
            end
            S_CHANGE: begin
                w_rej_nxt    = w_coin_in;
                w_credit_nxt = r_credit - L_ONE_C;
                if (r_credit <= L_ONE_C) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CHANGE;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = {CREDIT_W{1'b0}};
                w_timer_nxt  = {TMR_W{1'b0}};
            end
        endcase
    end

    // State, credit and timer registers; Moore outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_credit   <= {CREDIT_W{1'b0}};
            r_timer    <= {TMR_W{1'b0}};
            r_pr       <= 1'b0;
            r_change   <= 1'b0;
            r_coin_rej <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_timer    <= w_timer_nxt;
            r_pr       <= (w_state_nxt == S_VEND);
            r_change   <= (w_state_nxt == S_CHANGE);
            r_coin_rej <= w_rej_nxt;
        end
    end

    assign pr       = r_pr;
    assign change   = r_change;
    assign coin_rej = r_coin_rej;
    assign credit   = r_credit;

endmodule
